// File: rtl/l1_pkg.sv
// rtl/l1_pkg.sv - shared constants and FSM state type for the layer-1 result readout path
package l1_pkg;

  localparam int DATA_W = 20;
  localparam int ADDR_W = 12;
  localparam int IDX_W  = 10;
  localparam int SUM_W  = 30;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } l1_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head and occupancy count
module sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  // Pushes into a full FIFO and pops from an empty one are dropped.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Storage, pointers and count; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + (PTR_W + 1)'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - (PTR_W + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/l1_stream_out.sv
// rtl/l1_stream_out.sv - streams the layer-1 result map to the host with prefetch and checksum
module l1_stream_out #(
  parameter int DATA_W     = l1_pkg::DATA_W,
  parameter int ADDR_W     = l1_pkg::ADDR_W,
  parameter int NUM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  output logic [2:0]        csel,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [9:0]        out_idx,
  output logic              out_last,
  output logic [29:0]       sum_out,
  output logic              done
);

  import l1_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);

  l1_state_e         state_q;
  logic              busy_q;
  logic              done_q;
  logic              inflight_q;
  logic [IDX_W-1:0]  rd_idx_q;
  logic [IDX_W-1:0]  out_idx_q;
  logic [ADDR_W-1:0] caddr_q;
  logic [SUM_W-1:0]  sum_q;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [CNT_W:0]    occupancy;
  logic              issue;
  logic              pop;
  logic              last_pop;

  // A read is only issued when the word it returns is guaranteed a FIFO slot.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign issue     = (state_q == ST_READ) && !fifo_full && (occupancy < DEPTH_OCC);
  assign pop       = !fifo_empty && out_ready;
  assign last_pop  = pop && (out_idx_q == LAST_IDX);

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (inflight_q),
    .wdata_i (cdata_rd),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Transfer FSM plus read-index and in-flight tracking.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      rd_idx_q   <= '0;
      caddr_q    <= '0;
    end else begin
      inflight_q <= issue;
      done_q     <= 1'b0;
      if (issue) begin
        caddr_q  <= ADDR_W'(rd_idx_q);
        rd_idx_q <= rd_idx_q + IDX_W'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q  <= ST_READ;
            busy_q   <= 1'b1;
            rd_idx_q <= '0;
          end
        end
        ST_READ: begin
          if (issue && (rd_idx_q == LAST_IDX)) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (last_pop) begin
            state_q <= ST_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output index and running checksum; both restart on an accepted start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_idx_q <= '0;
      sum_q     <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      out_idx_q <= '0;
      sum_q     <= '0;
    end else if (pop) begin
      out_idx_q <= out_idx_q + IDX_W'(1);
      sum_q     <= sum_q + SUM_W'(fifo_head);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign crd       = issue;
  assign caddr_rd  = issue ? ADDR_W'(rd_idx_q) : caddr_q;
  assign csel      = busy_q ? CSEL_L1 : CSEL_NONE;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head;
  assign out_idx   = out_idx_q;
  assign out_last  = !fifo_empty && (out_idx_q == LAST_IDX);
  assign sum_out   = sum_q;

endmodule

// File: tb/tb_l1_stream_out.sv
// tb/tb_l1_stream_out.sv - randomized self-checking bench for l1_stream_out
module tb_l1_stream_out;

  localparam int DW     = 20;
  localparam int AW     = 12;
  localparam int NW     = 1024;
  localparam int FD     = 4;
  localparam int BUDGET = 8000;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          start     = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] cdata_rd  = '0;
  logic          busy;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [2:0]    csel;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [9:0]    out_idx;
  logic          out_last;
  logic [29:0]   sum_out;
  logic          done;

  l1_stream_out #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .NUM_WORDS  (NW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .crd       (crd),
    .caddr_rd  (caddr_rd),
    .csel      (csel),
    .cdata_rd  (cdata_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .sum_out   (sum_out),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem [NW];

  logic [DW-1:0] obs_data [$];
  int            obs_idx  [$];
  bit            obs_last [$];
  int            rd_addr  [$];

  int            t_start, done_cnt, done_cyc, first_valid_cyc, first_read_cyc;
  int            last_read_cyc, last_hs_cyc, hold_err, csel_err, busy_err, max_occ;
  int            stall_reads;
  logic          stall_crd;
  logic [DW-1:0] stall_data;
  logic [29:0]   sum_at_done;
  bit            aborted;

  logic          prev_valid, prev_ready;
  logic [DW-1:0] prev_data;
  logic [9:0]    prev_idx;
  bit            pend_rd;
  int            pend_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (crd === 1'b1) begin
      rd_addr.push_back(int'(caddr_rd));
      if (first_read_cyc < 0) first_read_cyc = cyc;
      last_read_cyc = cyc;
      if (csel !== 3'b011) csel_err++;
      if (rd_addr.size() - obs_data.size() > max_occ) max_occ = rd_addr.size() - obs_data.size();
    end
    if (prev_valid && !prev_ready &&
        (out_valid !== 1'b1 || out_data !== prev_data || out_idx !== prev_idx)) hold_err++;
    if (out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (out_valid === 1'b1 && out_ready) begin
      obs_data.push_back(out_data);
      obs_idx.push_back(int'(out_idx));
      obs_last.push_back(out_last);
      last_hs_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc    = cyc;
      sum_at_done = sum_out;
      if (busy !== 1'b0) busy_err++;
    end else if (cyc > t_start && done_cnt == 0 && busy !== 1'b1) begin
      busy_err++;
    end
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_data  = out_data;
    prev_idx   = out_idx;
    pend_rd    = crd;
    pend_addr  = int'(caddr_rd);
  endtask

  task automatic run(input int pct, input int stall, input int spur_at, input int abort_at);
    int post_done = 0;
    obs_data.delete(); obs_idx.delete(); obs_last.delete(); rd_addr.delete();
    done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; first_read_cyc = -1;
    last_read_cyc = -1; last_hs_cyc = -1; hold_err = 0; csel_err = 0; busy_err = 0;
    max_occ = 0; stall_reads = -1; stall_crd = 1'bx; stall_data = 'x; sum_at_done = 'x;
    prev_valid = 0; prev_ready = 0; pend_rd = 0; aborted = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    t_start   = cyc;
    out_ready = (stall > 0) ? 1'b0 : ($urandom_range(99) < pct);
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      sample();
      if (done_cnt > 0) post_done++;
      if (post_done > 3) break;
      if (stall > 0 && k == stall - 1) begin
        stall_reads = rd_addr.size();
        stall_crd   = crd;
        stall_data  = out_data;
      end
      if (abort_at >= 0 && obs_data.size() == abort_at) begin
        aborted = 1;
        break;
      end
      @(posedge clk); #1;
      start     = (k == spur_at);
      cdata_rd  = pend_rd ? mem[pend_addr & (NW - 1)] : DW'($urandom);
      out_ready = (k + 1 < stall) ? 1'b0 : ($urandom_range(99) < pct);
    end
  endtask

  task automatic check_run(input string name, input bit exact);
    int          bad_out = 0;
    int          bad_rd  = 0;
    logic [29:0] exp_sum = '0;
    for (int i = 0; i < NW; i++) exp_sum += 30'(mem[i]);
    for (int i = 0; i < obs_data.size() && i < NW; i++)
      if (obs_data[i] !== mem[i] || obs_idx[i] != i || obs_last[i] != (i == NW - 1)) bad_out++;
    for (int i = 0; i < rd_addr.size() && i < NW; i++)
      if (rd_addr[i] != i) bad_rd++;
    chk({name, ":words"},     obs_data.size(), NW);
    chk({name, ":order"},     bad_out, 0);
    chk({name, ":reads"},     rd_addr.size(), NW);
    chk({name, ":raddr"},     bad_rd, 0);
    chk({name, ":sum"},       sum_at_done, exp_sum);
    chk({name, ":done_cnt"},  done_cnt, 1);
    chk({name, ":hold"},      hold_err, 0);
    chk({name, ":busy"},      busy_err, 0);
    chk({name, ":csel"},      csel_err, 0);
    chk({name, ":no_ovf"},    max_occ <= FD, 1);
    if (exact) begin
      chk({name, ":first_rd"},  first_read_cyc - t_start, 1);
      chk({name, ":first_vld"}, first_valid_cyc - t_start, 3);
      chk({name, ":last_rd"},   last_read_cyc - t_start, NW);
      chk({name, ":last_hs"},   last_hs_cyc - t_start, NW + 2);
      chk({name, ":done_at"},   done_cyc - t_start, NW + 3);
    end
  endtask

  initial begin
    int late_done;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset:ctrl", {busy, crd, csel, out_valid, out_last, done, caddr_rd}, '0);
    chk("reset:data", {out_data, out_idx, sum_out}, '0);
    @(posedge clk); #1;
    reset = 1'b1;

    // 1: back-to-back ramp
    for (int i = 0; i < NW; i++) mem[i] = DW'(i);
    run(100, 0, -1, -1);
    check_run("ramp", 1);
    chk("ramp:sum_const", sum_at_done, 30'd523776);

    // 2: stall from the start, then release
    run(100, 20, -1, -1);
    chk("stall:reads", stall_reads, 4);
    chk("stall:crd_low", stall_crd, 1'b0);
    chk("stall:data", stall_data, mem[0]);
    check_run("stall", 0);

    // 3: random data, 30% ready
    for (int i = 0; i < NW; i++) mem[i] = DW'($urandom);
    run(30, 0, -1, -1);
    check_run("rand30", 0);

    // 4: maximum data
    for (int i = 0; i < NW; i++) mem[i] = 20'hFFFFF;
    run(100, 0, -1, -1);
    check_run("max", 1);
    chk("max:sum_const", sum_at_done, 30'h3FFFFC00);

    // 5: reset mid-transfer, then a fresh transfer
    for (int i = 0; i < NW; i++) mem[i] = DW'($urandom);
    run(70, 0, -1, 500);
    chk("abort:reached", aborted, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset    = 1'b1;
    cdata_rd = DW'($urandom);
    @(negedge clk);
    chk("abort:ctrl", {busy, crd, csel, out_valid, out_last, done, caddr_rd}, '0);
    chk("abort:data", {out_data, out_idx, sum_out}, '0);
    late_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) late_done++;
    end
    chk("abort:no_done", late_done, 0);
    run(50, 0, -1, -1);
    check_run("rerun", 0);

    // 6: spurious start while busy
    for (int i = 0; i < NW; i++) mem[i] = DW'($urandom);
    run(100, 0, 99, -1);
    check_run("spur", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l1_stream_out.md
# l1_stream_out

Downstream consumer of the convolution/max-pool engine. After the engine finishes, this block reads the 32×32 layer-1 map (1024 words, bank `csel = 3'b011`) from the shared result memory in raster order. It streams the words to the host over a valid/ready interface through a small prefetch FIFO, and reports a running unsigned checksum of everything it streamed.

## Interface
Parameters:
- `DATA_W`, 20: result-memory word width.
- `ADDR_W`, 12: result-memory address width.
- `NUM_WORDS`, 1024: layer-1 words to stream.
- `FIFO_DEPTH`, 4: prefetch entries; power of two, ≥2.

Ports:
- `clk`: input, 1. Single clock, rising edge.
- `reset`: input, 1. Reset is synchronous and active-low.
- `start`: input, 1. One-cycle pulse from the conv engine when layer 1 is complete.
- `busy`: output, 1. High from the cycle after an accepted `start` until `done`.
- `crd`: output, 1. Result-memory read strobe.
- `caddr_rd`: output, `ADDR_W`. Read address: word index, zero-extended.
- `csel`: output, 3. Bank select: `3'b011` while `busy`, else `3'b000`.
- `cdata_rd`: input, `DATA_W`. Read data, valid the cycle after `crd`=1.
- `out_valid`: output, 1. Stream word available.
- `out_ready`: input, 1. Host accepts the word.
- `out_data`: output, `DATA_W`. Stream word.
- `out_idx`: output, 10. Raster index of `out_data`.
- `out_last`: output, 1. High with index `NUM_WORDS-1`.
- `sum_out`: output, 30. Unsigned sum of all accepted words; final value is valid when `done`=1.
- `done`: output, 1. One-cycle pulse when the transfer is complete.

## Operation
- **Reset.** `reset`=0 at a rising edge clears every output and internal register to 0.
  - FSM goes to IDLE.
  - FIFO is emptied.
  - Any in-flight read is discarded.
  - Reset mid-transfer abandons the transfer; no `done` is produced.
- **FSM states.** IDLE, READ, DRAIN, FIN.
  - IDLE → READ on `start`=1. `start` in any other state is ignored.
  - READ: issue a read when `issue = (fifo_count + inflight) < FIFO_DEPTH`.
    - The read drives `crd`=1 and `caddr_rd`=`rd_idx`, then `rd_idx` increments.
    - `inflight` is a 1-bit flag: it equals `crd` from the previous cycle.
    - READ → DRAIN in the cycle after the issue with `rd_idx`=`NUM_WORDS-1`.
  - DRAIN: no reads are issued. DRAIN → FIN when the `out_last` word is accepted.
  - FIN: assert `done` for one cycle, clear `busy`, then go to IDLE.
- **FIFO.**
  - Push: `cdata_rd` is pushed when `inflight`=1.
  - Pop: on `out_valid & out_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - Overflow is impossible by the issue rule. Overflow is an assertion error in the bench.
- **Stream.**
  - `out_valid` = FIFO not empty. `out_data` = FIFO head.
  - `out_idx` counts accepted words.
  - `out_data` and `out_idx` hold stable while `out_valid & !out_ready`.
  - Once asserted, `out_valid` never drops without a handshake.
- **Checksum.**
  - `sum_out` clears on an accepted `start`.
  - Each handshake adds `out_data`, zero-extended to 30 bits.
  - 1024·(2²⁰−1) fits in 30 bits, so the sum cannot overflow.
- **Data treatment.** Words are treated as raw unsigned. Pool output is already ReLU'd, so all words are non-negative.

## Timing
- `start` at cycle T:
  - T+1: `busy`=1, `crd`=1, `caddr_rd`=0.
  - T+2: data for index 0 is on `cdata_rd`.
  - T+3: `out_valid`=1 with index 0.
- With `out_ready` held high:
  - One read per cycle and one word out per cycle.
  - Last read issued at T+1024.
  - Last handshake at T+1026.
  - `done` pulses at T+1027, and `busy` is 0 from T+1027.
- **Backpressure.**
  - With `out_ready`=0, reads stop once `fifo_count + inflight = FIFO_DEPTH`.
  - Reads resume the cycle after a pop makes the issue condition true.
- **`caddr_rd`** holds its last value when `crd`=0.

## Structure
- Package `l1_pkg` holds:
  - `DATA_W`, `ADDR_W`.
  - `CSEL_L0` = `3'b001` and `CSEL_L1` = `3'b011`.
  - The FSM state enum.
  - The conv engine imports the same package.
- Sub-module `sync_fifo`: parameterised width and depth. It has push/pop/full/empty/count and a combinational head output. It uses the same clock and the same active-low synchronous reset.
- Top level holds the FSM, index counters, issue logic and checksum.

## Test plan
1. **Back-to-back stream.** Memory word i = i; `out_ready`=1; `start` at T.
   - Required: 1024 words with `out_idx`=`out_data`=0..1023, `out_last` only at 1023.
   - `done` at T+1027; `sum_out`=523776.
2. **Stall.** Hold `out_ready`=0 from T.
   - Required: exactly 4 reads, `caddr_rd` 0..3, then `crd`=0.
   - `out_data`=0 held stable.
   - Release `out_ready`: streaming resumes with no loss or duplication.
3. **Random backpressure.** `out_ready` random at 30% duty; memory words random in 0..2²⁰−1.
   - Required: output sequence equals memory contents in order; `sum_out` matches the model.
4. **Maximum data.** All words 20'hFFFFF.
   - Required: `sum_out`=30'h3FFFFC00.
5. **Reset mid-transfer.** `reset`=0 at word 500 for one cycle, then a new `start`.
   - Required: all outputs 0 the cycle after reset; no `done` for the aborted run.
   - The second run is complete and correct.
6. **Spurious start.** Second `start` pulse while `busy`.
   - Required: ignored; the transfer and `sum_out` are unaffected.
